posit_mul_scheduler: RTL and testbench
======================================

Name: posit_mul_scheduler

Overview:
- Shares one registered posit multiplier among R requesters using round-robin arbitration and valid/ready handshakes.
- Tracks each in-flight operation with a tag pipeline matched to the multiplier latency.
- Buffers results, tagged with requester id, in a response FIFO. Issue is credit-limited so the FIFO never overflows.
- Also sequences the multiplier's synchronous active-high reset after system reset.

Parameters:
- N, 16, posit word width.
- ES, 2, exponent field width; passed through to the multiplier instance, no local use.
- R, 4, number of requesters (2..8).
- MUL_LAT, 2, cycles from mul_a/mul_b driven to mul_out valid.
- FIFO_DEPTH, 4, response FIFO entries (power of 2, >= MUL_LAT).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low system reset.
- req_valid  in  R  per-requester operand valid.
- req_a  in  R*N  operand A; requester i in bits [i*N +: N].
- req_b  in  R*N  operand B, same packing as req_a.
- req_ready  out  R  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- mul_reset  out  1  synchronous active-high reset to the multiplier.
- mul_a  out  N  operand A to the multiplier.
- mul_b  out  N  operand B to the multiplier.
- mul_out  in  N  multiplier result.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer accepts the head.
- rsp_data  out  N  product.
- rsp_id  out  clog2(R)  requester index of the product.

Behaviour:
- Reset (reset low, asynchronous):
  - state=INIT, init counter=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0.
  - mul_a=mul_b=0, mul_reset=1.
  - rr pointer=0, tag pipe cleared, FIFO empty, inflight=0.
- INIT state:
  - mul_reset=1 for MUL_LAT+1 cycles after reset deasserts, then state goes to RUN; mul_reset=0 in RUN.
  - No grants in INIT.
- Grant (combinational), issued only when all hold:
  - state==RUN;
  - (fifo_count + inflight) < FIFO_DEPTH, using registered values; a pop in the same cycle does not free credit until the next cycle.
- Arbitration:
  - The granted requester is the first i with req_valid[i]=1, searching from rr pointer upward modulo R.
  - Exactly one req_ready bit is high when a grant is issued, else all are low.
  - req_ready may go high only for a requester whose req_valid is high.
- mul_a/mul_b are combinational from the granted requester's operands; both are 0 when there is no grant (a 0*0 product is discarded).
- On grant, registered updates:
  - rr pointer <= granted index + 1 (mod R).
  - Tag pipe stage 0 <= {1, id}; otherwise stage 0 <= {0, x}.
  - The tag pipe is MUL_LAT stages deep and shifts every cycle.
- inflight counts valid tag-pipe entries: +1 on grant, -1 when the final stage is valid. Both in the same cycle leaves it unchanged.
- Capture: when the final tag stage is valid, push {mul_out, id} into the FIFO in that cycle.
- FIFO behaviour:
  - Head drives rsp_data, rsp_id and rsp_valid=(count>0); pop occurs on rsp_valid && rsp_ready.
  - Push and pop in the same cycle are both honoured, count unchanged.
  - Pop on empty is ignored.
  - Push on full cannot occur by construction; if it does, an assertion fires.
- Ordering: responses leave in grant order. No requester starves: with all valid, grants cycle 0,1,..,R-1 repeatedly.
- Holding: a requester whose valid stays high with no grant keeps its operands stable; the scheduler does not check this.
- Mid-operation reset: all in-flight tags and FIFO contents are dropped, rsp_valid falls immediately, and INIT re-runs.

Test Plan:
- Bring-up: release reset with req_valid[0]=1 held -> mul_reset high exactly MUL_LAT+1 cycles, req_ready=0 throughout, first grant in the first RUN cycle.
- Single op: requester 2 sends A=0x4000 (1.0), B=0x4800 (2.0), rsp_ready=1 -> rsp_valid one cycle after capture (MUL_LAT+1 cycles after grant), rsp_data=0x4800, rsp_id=2.
- Round-robin fairness: all 4 requesters valid continuously, rsp_ready=1 -> grant sequence 0,1,2,3,0,1,... Responses arrive in the same order; each requester gets 1 of every 4 grants.
- Backpressure and credit:
  - rsp_ready=0 with continuous requests -> exactly FIFO_DEPTH grants, then req_ready stays 0.
  - FIFO holds 4 entries and never overflows.
  - Raising rsp_ready for one cycle -> one pop, then one new grant the following cycle.
- Specials: A=0x0000, B=0x4000 -> rsp_data=0x0000; A=0x8000 (NaR), B=0x4800 -> rsp_data=0x8000; rsp_id matches the requester.
- Reset mid-stream: assert reset with 2 ops in flight and 2 in the FIFO -> rsp_valid=0 and req_ready=0 asynchronously. After release, no stale responses appear and INIT repeats.

Source files
------------

// File: rtl/posit_mul_scheduler.sv
// Round-robin scheduler sharing one registered posit multiplier among R requesters.
// Each issued operation carries a tag down a pipe matched to the multiplier latency.
// Products land in a response FIFO, and issue is credit-limited so the FIFO never overflows.
// The block also holds the multiplier in reset for MUL_LAT+1 cycles after system reset.
module posit_mul_scheduler #(
  parameter int unsigned N          = 16,
  parameter int unsigned ES         = 2,
  parameter int unsigned R          = 4,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [R-1:0]           req_valid,
  input  logic [R*N-1:0]         req_a,
  input  logic [R*N-1:0]         req_b,
  output logic [R-1:0]           req_ready,
  output logic                   mul_reset,
  output logic [N-1:0]           mul_a,
  output logic [N-1:0]           mul_b,
  input  logic [N-1:0]           mul_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [N-1:0]           rsp_data,
  output logic [$clog2(R)-1:0]   rsp_id
);

  localparam int unsigned IdW   = $clog2(R);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned InitW = $clog2(MUL_LAT + 1) + 1;

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [InitW-1:0] init_cnt_q, init_cnt_d;
  logic [IdW-1:0]   rr_q, rr_d;
  logic [CntW-1:0]  inflight_q, inflight_d;
  logic [CntW-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [MUL_LAT-1:0] tag_vld_q;
  logic [IdW-1:0]   tag_id_q [MUL_LAT];
  logic [N-1:0]     fifo_data_q [FIFO_DEPTH];
  logic [IdW-1:0]   fifo_id_q [FIFO_DEPTH];

  logic             gnt_found;
  logic [IdW-1:0]   gnt_idx;
  logic             grant;
  logic             credit_ok;
  logic [CntW:0]    credit_used;
  logic             push;
  logic             pop;
  logic             fifo_full;

  // Init sequencing: hold the multiplier in reset for MUL_LAT+1 cycles, then run.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == StInit) begin
      if (init_cnt_q == InitW'(MUL_LAT)) begin
        state_d = StRun;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end
  end

  assign mul_reset = (state_q == StInit);

  // Credit uses registered occupancy only, so a same-cycle pop frees nothing until next cycle.
  assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
  assign credit_ok   = credit_used < (CntW + 1)'(FIFO_DEPTH);

  // Round-robin search: first valid requester at or after the pointer, wrapping modulo R.
  always_comb begin
    int cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < int'(R); k++) begin
      cand = int'(rr_q) + k;
      if (cand >= int'(R)) cand = cand - int'(R);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdW'(cand);
      end
    end
  end

  assign grant = (state_q == StRun) && credit_ok && gnt_found;

  // Grant vector and operand mux; zero operands when idle so the multiplier sees a benign 0*0.
  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    if (grant) begin
      req_ready = R'(1) << gnt_idx;
      mul_a     = req_a[gnt_idx*N +: N];
      mul_b     = req_b[gnt_idx*N +: N];
    end
  end

  // Pointer advances past the winner so it becomes lowest priority next time.
  always_comb begin
    rr_d = rr_q;
    if (grant) begin
      rr_d = (gnt_idx == IdW'(R - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign push = tag_vld_q[MUL_LAT-1];
  assign pop  = rsp_valid && rsp_ready;

  // Occupancy counters for the tag pipe and the response FIFO.
  always_comb begin
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({grant, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Control state: FSM, arbiter pointer, tag pipe, counters and FIFO pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      rr_q       <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_vld_q  <= '0;
      for (int i = 0; i < int'(MUL_LAT); i++) tag_id_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      rr_q         <= rr_d;
      inflight_q   <= inflight_d;
      fifo_cnt_q   <= fifo_cnt_d;
      tag_vld_q[0] <= grant;
      tag_id_q[0]  <= grant ? gnt_idx : '0;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the outputs are gated by rsp_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mul_out;
      fifo_id_q[wr_ptr_q]   <= tag_id_q[MUL_LAT-1];
    end
  end

  assign fifo_full = (fifo_cnt_q == CntW'(FIFO_DEPTH));
  assign rsp_valid = (fifo_cnt_q != '0);
  assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign rsp_id    = rsp_valid ? fifo_id_q[rd_ptr_q] : '0;

  // Parameter sanity and structural invariants.
  a_params: assert property (@(posedge clk)
    (ES < N) && (R >= 2) && (R <= 8) && (FIFO_DEPTH >= MUL_LAT) && (FIFO_DEPTH >= 2));
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));
  a_onehot_grant: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));
  a_grant_valid: assert property (@(posedge clk) disable iff (!reset)
    (req_ready & ~req_valid) == '0);

endmodule

// File: tb/tb_posit_mul_scheduler.sv
// Directed bench for posit_mul_scheduler with a two-stage stub multiplier.
module tb_posit_mul_scheduler;
  localparam int N          = 16;
  localparam int R          = 4;
  localparam int MUL_LAT    = 2;
  localparam int FIFO_DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   req_ready;
  logic           mul_reset;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic [N-1:0]   mul_out;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_data;
  logic [1:0]     rsp_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  posit_mul_scheduler #(
    .N(N), .ES(2), .R(R), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_reset(mul_reset), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out(mul_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  // Exact for the operand classes used here: NaR, zero, and multiplication by 1.0.
  function automatic logic [15:0] stub_mul(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h8000 || b == 16'h8000) return 16'h8000;
    if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
    if (a == 16'h4000) return b;
    if (b == 16'h4000) return a;
    return 16'hdead;
  endfunction

  logic [15:0] m_s1;
  always @(posedge clk) begin
    if (mul_reset) begin
      m_s1    <= '0;
      mul_out <= '0;
    end else begin
      m_s1    <= stub_mul(mul_a, mul_b);
      mul_out <= m_s1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic test_reset();
    int hi;
    bit run_seen;
    hi = 0;
    run_seen = 1'b0;
    reset = 1'b1;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    set_op(0, 16'h4000, 16'h4000);
    #1 reset = 1'b0;
    repeat (3) step();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h exp 0000", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
    checks++; if (mul_reset !== 1'b1) begin errors++; $display("FAIL reset_mul_reset got %b exp 1", mul_reset); end
    checks++; if (mul_a !== 16'h0000 || mul_b !== 16'h0000) begin errors++; $display("FAIL reset_mul_ops got %h/%h exp 0000/0000", mul_a, mul_b); end
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mul_reset === 1'b1) begin
        hi++;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL init_no_grant got %b exp 0000", req_ready); end
      end else begin
        run_seen = 1'b1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL first_run_grant got %b exp 0001", req_ready); end
        req_valid = '0;
        break;
      end
      step();
    end
    checks++; if (run_seen !== 1'b1) begin errors++; $display("FAIL run_reached got %b exp 1", run_seen); end
    checks++; if (hi !== MUL_LAT + 1) begin errors++; $display("FAIL init_len got %0d exp %0d", hi, MUL_LAT + 1); end
  endtask

  task automatic test_single_op();
    step();
    set_op(2, 16'h4000, 16'h4800);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", req_ready); end
    checks++; if (mul_a !== 16'h4000 || mul_b !== 16'h4800) begin errors++; $display("FAIL single_ops got %h/%h exp 4000/4800", mul_a, mul_b); end
    step(); req_valid = '0; #1;
    checks++; if (mul_a !== 16'h0000) begin errors++; $display("FAIL idle_mul_a got %h exp 0000", mul_a); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early1 got %b exp 0", rsp_valid); end
    step(); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early2 got %b exp 0", rsp_valid); end
    step(); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h4800 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL single_rsp got v=%b d=%h id=%0d exp v=1 d=4800 id=2", rsp_valid, rsp_data, rsp_id);
    end
    step(); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %b exp 0", rsp_valid); end
  endtask

  // Pointer sits at 3 after the single op on requester 2.
  task automatic test_round_robin();
    int gcnt [4];
    int eg;
    int er;
    for (int i = 0; i < 4; i++) begin
      gcnt[i] = 0;
      set_op(i, 16'h4000, 16'(16'h4800 + i));
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      for (int i = 0; i < 4; i++) if (req_ready[i] === 1'b1) gcnt[i]++;
      if (k < 8) begin
        eg = (3 + k) % 4;
        checks++; if (req_ready !== (4'b0001 << eg)) begin errors++; $display("FAIL rr_grant k=%0d got %b exp id %0d", k, req_ready, eg); end
      end
      if (k >= 3 && k < 11) begin
        er = k % 4;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(er) || rsp_data !== 16'(16'h4800 + er)) begin
          errors++; $display("FAIL rr_rsp k=%0d got v=%b id=%0d d=%h exp id=%0d", k, rsp_valid, rsp_id, rsp_data, er);
        end
      end
      if (k == 11) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drained got %b exp 0", rsp_valid); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (gcnt[i] !== 2) begin errors++; $display("FAIL rr_share id=%0d got %0d exp 2", i, gcnt[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] eg;
    int n;
    int exp_id [4];
    exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 2; exp_id[3] = 3;
    rsp_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      req_valid = 4'hF;
      #1;
      eg = (k < 4) ? (4'b0001 << ((3 + k) % 4)) : 4'b0000;
      checks++; if (req_ready !== eg) begin errors++; $display("FAIL bp_grant k=%0d got %b exp %b", k, req_ready, eg); end
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 16'h4803) begin
      errors++; $display("FAIL bp_head got v=%b id=%0d d=%h exp v=1 id=3 d=4803", rsp_valid, rsp_id, rsp_data);
    end
    step(); rsp_ready = 1'b1; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_pop_no_credit got %b exp 0000", req_ready); end
    step(); rsp_ready = 1'b0; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_regrant got %b exp 1000", req_ready); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL bp_next_head got %0d exp 0", rsp_id); end
    step(); #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_full_again got %b exp 0000", req_ready); end
    req_valid = '0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step(); rsp_ready = 1'b1; #1;
      if (rsp_valid === 1'b1 && n < 4) begin
        checks++; if (rsp_id !== 2'(exp_id[n]) || rsp_data !== 16'(16'h4800 + exp_id[n])) begin
          errors++; $display("FAIL bp_drain n=%0d got id=%0d d=%h exp id=%0d", n, rsp_id, rsp_data, exp_id[n]);
        end
        n++;
      end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_drain_count got %0d exp 4", n); end
  endtask

  task automatic test_specials();
    int n;
    int exp_id [2];
    logic [15:0] exp_d [2];
    exp_id[0] = 1; exp_d[0] = 16'h0000;
    exp_id[1] = 3; exp_d[1] = 16'h8000;
    set_op(1, 16'h0000, 16'h4000);
    set_op(3, 16'h8000, 16'h4800);
    rsp_ready = 1'b1;
    step(); req_valid = 4'b1010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sp_grant1 got %b exp 0010", req_ready); end
    step(); req_valid = 4'b1000; #1;
    checks++; if (req_ready !== 4'b1000 || mul_a !== 16'h8000) begin
      errors++; $display("FAIL sp_grant3 got %b a=%h exp 1000 a=8000", req_ready, mul_a);
    end
    step(); req_valid = '0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid === 1'b1 && n < 2) begin
        checks++; if (rsp_id !== 2'(exp_id[n]) || rsp_data !== exp_d[n]) begin
          errors++; $display("FAIL sp_rsp n=%0d got id=%0d d=%h exp id=%0d d=%h", n, rsp_id, rsp_data, exp_id[n], exp_d[n]);
        end
        n++;
      end
      step();
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL sp_count got %0d exp 2", n); end
  endtask

  task automatic test_reset_mid();
    int hi;
    int stale;
    hi = 0;
    stale = 0;
    for (int i = 0; i < 4; i++) set_op(i, 16'h4000, 16'(16'h4800 + i));
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(); req_valid = 4'hF;
    end
    step(); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %b exp 1", rsp_valid); end
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_async got v=%b rdy=%b exp v=0 rdy=0000", rsp_valid, req_ready);
    end
    checks++; if (mul_reset !== 1'b1) begin errors++; $display("FAIL mid_mul_reset got %b exp 1", mul_reset); end
    req_valid = '0;
    step(); step();
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mul_reset !== 1'b1) break;
      hi++;
      step();
    end
    checks++; if (hi !== MUL_LAT + 1) begin errors++; $display("FAIL mid_init_len got %0d exp %0d", hi, MUL_LAT + 1); end
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      #1;
      if (rsp_valid !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale got %0d exp 0", stale); end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr_reset got %b exp 0001", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_specials();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
